// File: rtl/bsg_manycore_endpoint_credit_mux.sv
// Endpoint that joins one manycore processor port to num_nets_p forward/return
// network pairs. Outgoing packets are buffered in a small FIFO and handed
// round-robin to whichever forward network is ready. Every issued packet uses
// one remote-store credit. Any return arrival gives that credit back. A fence
// output reports when the FIFO is empty and no stores are still outstanding.
module bsg_manycore_endpoint_credit_mux #(
    parameter int num_nets_p         = 2,
    parameter int packet_width_p     = 64,
    parameter int ret_packet_width_p = 16,
    parameter int max_out_p          = 16,
    parameter int fifo_els_p         = 2,
    parameter int cnt_width_lp       = $clog2(max_out_p + 1)
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,

    input  logic                                     proc_v_i,
    input  logic [packet_width_p-1:0]                proc_data_i,
    output logic                                     proc_ready_o,
    input  logic                                     proc_fence_i,
    output logic                                     fence_done_o,

    output logic [num_nets_p-1:0]                    net_v_o,
    output logic [num_nets_p*packet_width_p-1:0]     net_data_o,
    input  logic [num_nets_p-1:0]                    net_ready_i,

    input  logic [num_nets_p-1:0]                    ret_v_i,
    input  logic [num_nets_p*ret_packet_width_p-1:0] ret_data_i,
    output logic [num_nets_p-1:0]                    ret_ready_o,

    output logic [cnt_width_lp-1:0]                  out_cnt_o,
    output logic                                     underflow_o
);

    localparam int ptr_width_lp = $clog2(fifo_els_p);
    localparam int occ_width_lp = $clog2(fifo_els_p + 1);
    localparam int rr_width_lp  = (num_nets_p > 1) ? $clog2(num_nets_p) : 1;
    // Four extra bits are enough for up to 8 simultaneous returns.
    localparam int sum_width_lp = cnt_width_lp + 4;

    localparam logic [cnt_width_lp-1:0] max_out_lp = cnt_width_lp'(max_out_p);
    localparam logic [occ_width_lp-1:0] fifo_els_lp = occ_width_lp'(fifo_els_p);

    // Helper functions

    // Advance a FIFO pointer, wrapping at the configured depth (need not be a power of two).
    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        if (int'(p) == fifo_els_p - 1) begin
            return '0;
        end
        return p + ptr_width_lp'(1);
    endfunction

    // Network index that is k positions after base, modulo num_nets_p.
    function automatic logic [rr_width_lp-1:0] rr_offset(input logic [rr_width_lp-1:0] base,
                                                         input int k);
        int s;
        s = int'(base) + k;
        if (s >= num_nets_p) begin
            s = s - num_nets_p;
        end
        return rr_width_lp'(s);
    endfunction

    // Number of returns arriving this cycle.
    function automatic logic [sum_width_lp-1:0] popcount(input logic [num_nets_p-1:0] v);
        logic [sum_width_lp-1:0] n;
        n = '0;
        for (int i = 0; i < num_nets_p; i++) begin
            n = n + sum_width_lp'(v[i]);
        end
        return n;
    endfunction

    // Net credit change for one cycle, clamped at zero.
    // The result is {underflow_hit, next_count}.
    function automatic logic [cnt_width_lp:0] credit_update(input logic [cnt_width_lp-1:0] cnt,
                                                            input logic                    issue,
                                                            input logic [sum_width_lp-1:0] rets);
        logic [sum_width_lp-1:0] avail;
        logic [sum_width_lp-1:0] diff;
        avail = sum_width_lp'(cnt) + sum_width_lp'(issue);
        diff  = avail - rets;
        if (rets > avail) begin
            return {1'b1, {cnt_width_lp{1'b0}}};
        end
        return {1'b0, diff[cnt_width_lp-1:0]};
    endfunction

    // State

    logic [packet_width_p-1:0] mem_q [fifo_els_p];
    logic [packet_width_p-1:0] mem_d [fifo_els_p];
    logic [ptr_width_lp-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ptr_width_lp-1:0]   rd_ptr_q, rd_ptr_d;
    logic [occ_width_lp-1:0]   occ_q, occ_d;
    logic [rr_width_lp-1:0]    rr_q, rr_d;
    logic [cnt_width_lp-1:0]   out_cnt_q, out_cnt_d;
    logic                      underflow_q, underflow_d;

    logic                      head_v;
    logic                      fifo_full;
    logic                      has_credit;
    logic                      sel_found;
    logic [rr_width_lp-1:0]    sel_idx;
    logic                      issue;
    logic                      enq;
    logic                      underflow_hit;
    logic [cnt_width_lp-1:0]   out_cnt_upd;

    // Return payloads carry no information beyond their arrival.
    logic                      unused_ret_data;
    assign unused_ret_data = ^ret_data_i;

    // Stage: processor-side handshake and issue decision on registered state

    assign head_v     = (occ_q != '0);
    assign fifo_full  = (occ_q == fifo_els_lp);
    assign has_credit = (out_cnt_q < max_out_lp);

    assign proc_ready_o = reset_n_i && !fifo_full && !proc_fence_i;
    assign enq          = proc_v_i && proc_ready_o;

    // Pick the first ready network, starting the search at the round-robin pointer.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < num_nets_p; k++) begin
            if (!sel_found && net_ready_i[rr_offset(rr_q, k)]) begin
                sel_found = 1'b1;
                sel_idx   = rr_offset(rr_q, k);
            end
        end
    end

    // Issue only if a packet is waiting, a credit is free and some network is ready.
    // A chosen network is ready, so asserting its valid means the handshake completes.
    assign issue = reset_n_i && head_v && has_credit && sel_found;

    // Assert valid on the single selected network. Every lane carries the head packet.
    always_comb begin
        net_v_o = '0;
        if (issue) begin
            net_v_o[sel_idx] = 1'b1;
        end
    end

    assign net_data_o = {num_nets_p{mem_q[rd_ptr_q]}};

    assign ret_ready_o  = {num_nets_p{reset_n_i}};
    assign out_cnt_o    = out_cnt_q;
    assign underflow_o  = underflow_q;
    assign fence_done_o = reset_n_i && proc_fence_i && !head_v && (out_cnt_q == '0);

    // Stage: next-state computation

    // FIFO storage and pointers. Enqueue and dequeue may occur in the same cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (enq) begin
            mem_d[wr_ptr_q] = proc_data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (issue) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({enq, issue})
            2'b10:   occ_d = occ_q + occ_width_lp'(1);
            2'b01:   occ_d = occ_q - occ_width_lp'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Round-robin pointer moves past the network that just took a packet.
    always_comb begin
        rr_d = rr_q;
        if (issue) begin
            rr_d = rr_offset(sel_idx, 1);
        end
    end

    // Outstanding-store count: one up per issue, one down per return, with a zero clamp.
    always_comb begin
        {underflow_hit, out_cnt_upd} = credit_update(out_cnt_q, issue, popcount(ret_v_i));
        out_cnt_d   = out_cnt_upd;
        underflow_d = underflow_q | underflow_hit;
    end

    // Stage: registers

    // Control state is cleared by reset. A reset while packets are buffered drops them.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            rr_q        <= '0;
            out_cnt_q   <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            rr_q        <= rr_d;
            out_cnt_q   <= out_cnt_d;
            underflow_q <= underflow_d;
        end
    end

    // FIFO payload storage. It is not reset; occupancy decides which entries are valid.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule
